// File: rtl/reg_dump_pkg.sv
// Shared types and sizing for the register-file dump reader.
// The CHKSUM state exists only when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
`ifdef REG_DUMP_CHECKSUM_EN
        , ST_CHKSUM
`endif
    } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready output stream of the register dump reader.
interface reg_dump_reader_if;
    import reg_dump_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_chk;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data, out_idx, out_chk, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_idx, out_chk, out_valid, out_last,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks R0..R(NUM_REGS-1) through one register-file read port and streams each word out.
// Optional macro REG_DUMP_CHECKSUM_EN appends a modular-sum checksum beat after the last register.
module reg_dump_reader
    import reg_dump_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    output logic [IDX_W-1:0]  SR_SEL,
    input  logic [DATA_W-1:0] SR_DATA,
    reg_dump_reader_if.master out_if,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_oidx;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
`ifdef REG_DUMP_CHECKSUM_EN
    logic              r_chk;
    logic [DATA_W-1:0] r_sum;
`endif

    // Walk FSM; every output is a register updated here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_oidx  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_chk   <= 1'b0;
            r_sum   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_idx   <= '0;
                        r_sel   <= '0;
                        r_busy  <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    // Capture happens on this edge, so a same-edge write is not seen.
                    r_data  <= SR_DATA;
                    r_oidx  <= r_idx;
                    r_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    r_last  <= 1'b0;
                    r_sum   <= r_sum + SR_DATA;
`else
                    r_last  <= (r_idx == LAST_IDX);
`endif
                    r_state <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_if.out_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_sel <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                            r_state <= ST_CHKSUM;
                            r_valid <= 1'b1;
                            r_last  <= 1'b1;
                            r_chk   <= 1'b1;
                            r_data  <= r_sum;
                            r_oidx  <= '0;
`else
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_sel   <= r_idx + IDX_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                ST_CHKSUM: begin
                    if (out_if.out_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_chk   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign SR_SEL           = r_sel;
    assign out_if.out_data  = r_data;
    assign out_if.out_idx   = r_oidx;
    assign out_if.out_valid = r_valid;
    assign out_if.out_last  = r_last;
    assign busy             = r_busy;
    assign done             = r_done;
`ifdef REG_DUMP_CHECKSUM_EN
    assign out_if.out_chk   = r_chk;
`else
    assign out_if.out_chk   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register-file model, beat scoreboard, table of dump runs and corner sequences.
module tb_reg_dump_reader;
    import reg_dump_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int DONE_BASE = 2 * NUM_REGS + 2;
    localparam int N_BEATS   = NUM_REGS + 1;
`else
    localparam int DONE_BASE = 2 * NUM_REGS + 1;
    localparam int N_BEATS   = NUM_REGS;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [IDX_W-1:0]  sr_sel;
    logic [DATA_W-1:0] sr_data;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    reg_dump_reader_if ifc();

    reg_dump_reader dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .start   (start),
        .SR_SEL  (sr_sel),
        .SR_DATA (sr_data),
        .out_if  (ifc.master),
        .busy    (busy),
        .done    (done)
    );

    // Register file model with one synchronous write port
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] model [NUM_REGS];
    logic              wr_en = 1'b0;
    logic [IDX_W-1:0]  wr_idx = '0;
    logic [DATA_W-1:0] wr_data = '0;
    assign sr_data = regs[sr_sel];
    always @(posedge clk) if (wr_en) regs[wr_idx] <= wr_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              chk;
    } beat_t;

    beat_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int c0 = 0;
    int stall_idx = -1;
    int stall_left = 0;
    int beats = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_valid = -1;
    bit prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: drives ready for the coming edge, then scores beats that will handshake on it.
    always @(negedge clk) begin
        beat_t cur;
        logic  rdy;
        beat_t e;
        cur = '{idx: ifc.out_idx, data: ifc.out_data, last: ifc.out_last, chk: ifc.out_chk};
        if (done) begin
            done_cnt++;
            done_cyc = cyc - c0;
        end
        if (ifc.out_valid && first_valid < 0) first_valid = cyc - c0;
        if (prev_stall && rst_n)
            check("stable_beat", ifc.out_valid && (cur == prev_beat), 32'(cur), 32'(prev_beat));
        if (ifc.out_valid && !cur.chk && int'(cur.idx) == stall_idx && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = 1'b1;
        end
        ifc.out_ready = rdy;
        prev_stall = ifc.out_valid && !rdy;
        prev_beat  = cur;
        if (ifc.out_valid && rdy && rst_n) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 1'b0, 32'(cur), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("beat", cur == e, 32'(cur), 32'(e));
            end
        end
    end

    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_idx  = IDX_W'(i);
            wr_data = model[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push_dump();
        logic [DATA_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sum = sum + model[i];
`ifdef REG_DUMP_CHECKSUM_EN
            exp_q.push_back('{idx: IDX_W'(i), data: model[i], last: 1'b0, chk: 1'b0});
`else
            exp_q.push_back('{idx: IDX_W'(i), data: model[i], last: (i == NUM_REGS - 1), chk: 1'b0});
`endif
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back('{idx: '0, data: sum, last: 1'b1, chk: 1'b1});
`endif
    endtask

    task automatic do_start();
        @(negedge clk);
        first_valid = -1;
        done_cyc = -1;
        beats = 0;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_rel(input int k);
        int b;
        b = 0;
        while ((cyc - c0) != k && b < 200) begin
            @(negedge clk);
            b++;
        end
        #2;
    endtask

    task automatic wait_done(input int d0);
        int b;
        b = 0;
        while (done_cnt == d0 && b < 100) begin
            @(negedge clk);
            #2;
            b++;
        end
        check("done_seen", done_cnt != d0, 32'(done_cnt), 32'(d0 + 1));
        repeat (3) @(negedge clk);
        #2;
        check("done_once", done_cnt == d0 + 1, 32'(done_cnt), 32'(d0 + 1));
        check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'(0));
        check("beat_count", beats == N_BEATS, 32'(beats), 32'(N_BEATS));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({sr_sel, ifc.out_data, ifc.out_idx, ifc.out_chk, ifc.out_valid,
                    ifc.out_last, busy, done});
    endfunction

    typedef struct {
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] mask;
        int                stall_idx;
        int                stall_n;
        int                exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0;
        vecs[0] = '{base: 16'h1000, mask: 16'h0000, stall_idx: -1, stall_n: 0, exp_done: DONE_BASE};
        vecs[1] = '{base: 16'h1000, mask: 16'h0000, stall_idx: 3,  stall_n: 3, exp_done: DONE_BASE + 3};
        vecs[2] = '{base: 16'h0000, mask: 16'hFFFF, stall_idx: 0,  stall_n: 1, exp_done: DONE_BASE + 1};
        vecs[3] = '{base: 16'hA5A5, mask: 16'h0F0F, stall_idx: 7,  stall_n: 2, exp_done: DONE_BASE + 2};

        #1 check("reset_outputs", out_vec() == 32'(0), out_vec(), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven dumps with optional backpressure on one beat
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NUM_REGS; i++)
                model[i] = (vecs[v].base + DATA_W'(i)) ^ vecs[v].mask;
            preload();
            push_dump();
            stall_idx  = vecs[v].stall_idx;
            stall_left = vecs[v].stall_n;
            d0 = done_cnt;
            do_start();
            wait_done(d0);
            check("done_cycle", done_cyc == vecs[v].exp_done, 32'(done_cyc), 32'(vecs[v].exp_done));
            check("first_valid", first_valid == 2, 32'(first_valid), 32'(2));
            check("idle_outputs", {sr_sel, ifc.out_valid, ifc.out_last, busy, done} == '0,
                  32'({sr_sel, ifc.out_valid, ifc.out_last, busy, done}), 32'(0));
        end
        stall_idx = -1;

        // Concurrent writes: R5 on its capture edge, R6 before its fetch
        for (int i = 0; i < NUM_REGS; i++) model[i] = 16'h1000 + DATA_W'(i);
        preload();
        push_dump();
        exp_q[6].data = 16'hBEEF;
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q[NUM_REGS].data = exp_q[NUM_REGS].data - 16'h1006 + 16'hBEEF;
`endif
        d0 = done_cnt;
        do_start();
        wait_rel(11);
        check("sr_sel_fetch5", sr_sel == IDX_W'(5) && busy, 32'({busy, sr_sel}), 32'({1'b1, IDX_W'(5)}));
        wr_en = 1'b1; wr_idx = IDX_W'(5); wr_data = 16'hBEEF;
        @(negedge clk);
        wr_idx = IDX_W'(6);
        @(negedge clk);
        wr_en = 1'b0;
        wait_done(d0);
        model[5] = 16'hBEEF;
        model[6] = 16'hBEEF;

        // Start held high through the whole dump: only one dump
        push_dump();
        d0 = done_cnt;
        @(negedge clk);
        beats = 0;
        start = 1'b1;
        c0 = cyc;
        begin
            int b;
            b = 0;
            while (done_cnt == d0 && b < 100) begin
                @(negedge clk);
                #2;
                b++;
            end
        end
        start = 1'b0;
        check("held_done_cycle", done_cyc == DONE_BASE, 32'(done_cyc), 32'(DONE_BASE));
        repeat (3) @(negedge clk);
        #2;
        check("held_single_dump", done_cnt == d0 + 1 && !busy && beats == N_BEATS,
              32'(beats), 32'(N_BEATS));

        // Start pulsed during DONE is ignored
        push_dump();
        d0 = done_cnt;
        do_start();
        begin
            int b;
            b = 0;
            while (done_cnt == d0 && b < 100) begin
                @(negedge clk);
                #2;
                b++;
            end
        end
        check("done_state", done, 32'(done), 32'(1));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("start_in_done_ignored", !busy && !ifc.out_valid && done_cnt == d0 + 1,
              32'({busy, ifc.out_valid}), 32'(0));

        // Reset during the R4 beat aborts without a done pulse
        push_dump();
        stall_idx  = 4;
        stall_left = 1000;
        d0 = done_cnt;
        do_start();
        wait_rel(10);
        check("r4_present", ifc.out_valid && ifc.out_idx == IDX_W'(4),
              32'({ifc.out_valid, ifc.out_idx}), 32'({1'b1, IDX_W'(4)}));
        rst_n = 1'b0;
        #1 check("async_reset_outputs", out_vec() == 32'(0), out_vec(), 32'(0));
        exp_q.delete();
        stall_left = 0;
        stall_idx  = -1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check("no_done_after_reset", done_cnt == d0, 32'(done_cnt), 32'(d0));
        push_dump();
        do_start();
        wait_done(d0);
        check("restart_first_valid", first_valid == 2, 32'(first_valid), 32'(2));

`ifdef REG_DUMP_CHECKSUM_EN
        // All-ones registers: sum wraps to 16'hFFF8
        for (int i = 0; i < NUM_REGS; i++) model[i] = 16'hFFFF;
        preload();
        push_dump();
        check("chk_expected_sum", exp_q[NUM_REGS].data == 16'hFFF8, 32'(exp_q[NUM_REGS].data), 32'hFFF8);
        d0 = done_cnt;
        do_start();
        wait_done(d0);
        check("chk_done_cycle", done_cyc == 2 * NUM_REGS + 2, 32'(done_cyc), 32'(2 * NUM_REGS + 2));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got t=%0t expected < 500000", $time);
        $fatal(1, "timeout");
    end

endmodule
